// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 8-bit Harvard RISC pipeline.
// Drives both instruction-memory read addresses and latches the fetched instruction toward decode.
module fetch_stage #(
   parameter logic [7:0] NOP_OPCODE = 8'h00,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       pc_in,
   input  logic             stall,
   input  logic             flush,
   output logic [7:0]       imem_addr0,
   output logic [7:0]       imem_addr1,
   input  logic [7:0]       imem_data0,
   input  logic [7:0]       imem_data1,
   output logic [7:0]       fetched_instruction,
   output logic             ifid_valid,
   output logic [7:0]       ifid_opcode,
   output logic [7:0]       ifid_imm,
   output logic             ifid_two_byte,
   output logic [7:0]       ifid_pc,
   output logic [7:0]       ifid_pc_next,
   output logic [CNT_W-1:0] fetch_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Opcodes 0xC0..0xCB carry an immediate byte; everything else is a single byte.
   function automatic logic is_two_byte(input logic [7:0] op);
      return (op[7:4] == 4'hC) && (op[3:2] != 2'b11);
   endfunction

   logic             valid_r, valid_s;
   logic [7:0]       opcode_r, opcode_s;
   logic [7:0]       imm_r, imm_s;
   logic             two_byte_r, two_byte_s;
   logic [7:0]       pc_r, pc_s;
   logic [7:0]       pc_next_r, pc_next_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             data0_two_s;

   assign imem_addr0          = pc_in;
   assign imem_addr1          = pc_in + 8'd1;
   assign fetched_instruction = imem_data0;
   assign data0_two_s         = is_two_byte(imem_data0);

   // Next IF/ID contents: stall outranks flush, flush outranks a fresh load.
   always_comb begin
      valid_s    = valid_r;
      opcode_s   = opcode_r;
      imm_s      = imm_r;
      two_byte_s = two_byte_r;
      pc_s       = pc_r;
      pc_next_s  = pc_next_r;
      cnt_s      = cnt_r;
      casez ({stall, flush})
         2'b1?: begin
            valid_s = valid_r;
         end
         2'b01: begin
            valid_s    = 1'b0;
            opcode_s   = NOP_OPCODE;
            imm_s      = 8'h00;
            two_byte_s = 1'b0;
         end
         default: begin
            valid_s    = 1'b1;
            opcode_s   = imem_data0;
            two_byte_s = data0_two_s;
            pc_s       = pc_in;
            if (data0_two_s) begin
               imm_s     = imem_data1;
               pc_next_s = pc_in + 8'd2;
            end else begin
               imm_s     = 8'h00;
               pc_next_s = pc_in + 8'd1;
            end
            if (cnt_r != CNT_MAX) begin
               cnt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_s = cnt_r;
            end
         end
      endcase
   end

   // IF/ID register and fetch counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r    <= 1'b0;
         opcode_r   <= NOP_OPCODE;
         imm_r      <= 8'h00;
         two_byte_r <= 1'b0;
         pc_r       <= 8'h00;
         pc_next_r  <= 8'h00;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         valid_r    <= valid_s;
         opcode_r   <= opcode_s;
         imm_r      <= imm_s;
         two_byte_r <= two_byte_s;
         pc_r       <= pc_s;
         pc_next_r  <= pc_next_s;
         cnt_r      <= cnt_s;
      end
   end

   assign ifid_valid    = valid_r;
   assign ifid_opcode   = opcode_r;
   assign ifid_imm      = imm_r;
   assign ifid_two_byte = two_byte_r;
   assign ifid_pc       = pc_r;
   assign ifid_pc_next  = pc_next_r;
   assign fetch_count   = cnt_r;

endmodule
